// File: rtl/prog_lut_pkg.sv
// rtl/prog_lut_pkg.sv - shared types and constants for the programmable truth-table evaluator
package prog_lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_t;

    localparam logic [7:0] LUT_TABLE_DEFAULT = 8'h39;

    function automatic int lut_depth(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/prog_lut_loader.sv
// rtl/prog_lut_loader.sv - serial table loader: shifts bits into a shadow table and commits it
module prog_lut_loader
    import prog_lut_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_valid,
    input  logic                    cfg_bit,
    output logic                    cfg_ready,
    output logic                    cfg_done,
    output logic [lut_depth(N)-1:0] commit_table
);

    localparam int DEPTH = lut_depth(N);
    localparam int CW    = $clog2(DEPTH) + 1;

    lut_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]  shadow_q, shadow_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // A restart wins over a bit presented in the same cycle
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    shadow_d[cnt_q[N-1:0]] = cfg_bit;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DEPTH - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_ready    = (state_q == LOAD);
    assign cfg_done     = (state_q == COMMIT);
    assign commit_table = shadow_q;

endmodule

// File: rtl/prog_lut.sv
// rtl/prog_lut.sv - run-time programmable N-input truth table with CH registered lookup channels
module prog_lut
    import prog_lut_pkg::*;
#(
    parameter int                      N           = 3,
    parameter int                      CH          = 1,
    parameter logic [(1 << N)-1:0]     RESET_TABLE = LUT_TABLE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [CH*N-1:0] in_data,
    output logic            out_valid,
    output logic [CH-1:0]   out_y
);

    localparam int DEPTH = lut_depth(N);

    logic [DEPTH-1:0] active_table;
    logic [DEPTH-1:0] commit_table;

    prog_lut_loader #(.N(N)) u_loader (
        .clk          (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_bit      (cfg_bit),
        .cfg_ready    (cfg_ready),
        .cfg_done     (cfg_done),
        .commit_table (commit_table)
    );

    // Lookups sampled on the commit edge still see the old table
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_table <= RESET_TABLE;
            out_valid    <= 1'b0;
        end else begin
            if (cfg_done) begin
                active_table <= commit_table;
            end
            out_valid <= in_valid;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic y_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                y_q <= 1'b0;
            end else if (in_valid) begin
                y_q <= active_table[in_data[k*N +: N]];
            end
        end

        assign out_y[k] = y_q;
    end

endmodule

// File: tb/tb_prog_lut.sv
// tb/tb_prog_lut.sv - self-checking bench for prog_lut with single- and dual-channel instances
module tb_prog_lut;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;

    logic       ready1, done1, valid1;
    logic [0:0] y1;
    logic       ready2, done2, valid2;
    logic [1:0] y2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    prog_lut #(.N(3), .CH(1)) dut1 (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_bit(cfg_bit), .cfg_ready(ready1), .cfg_done(done1),
        .in_valid(in_valid), .in_data(in_data[2:0]), .out_valid(valid1), .out_y(y1)
    );

    prog_lut #(.N(3), .CH(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_bit(cfg_bit), .cfg_ready(ready2), .cfg_done(done2),
        .in_valid(in_valid), .in_data(in_data), .out_valid(valid2), .out_y(y2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: table, queue of received bits, load/commit flags
    logic [7:0] mtab;
    logic [7:0] mnew;
    bit         mq[$];
    bit         loading = 0;
    bit         committing = 0;
    bit         started = 0;
    logic       mvalid;
    logic [1:0] my;

    always @(posedge clk) begin
        if (!reset) begin
            mtab = 8'h39; mq.delete(); loading = 0; committing = 0;
            mvalid = 0; my = 2'b00; started = 1;
        end else begin
            if (in_valid) my = {mtab[in_data[5:3]], mtab[in_data[2:0]]};
            mvalid = in_valid;
            if (committing) begin
                mtab = mnew;
                committing = 0;
            end else if (cfg_start) begin
                mq.delete();
                loading = 1;
            end else if (loading && cfg_valid) begin
                mq.push_back(cfg_bit);
                if (mq.size() == 8) begin
                    for (int i = 0; i < 8; i++) mnew[i] = mq[i];
                    loading = 0;
                    committing = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_ready1", {7'd0, ready1}, {7'd0, loading});
            chk("m_ready2", {7'd0, ready2}, {7'd0, loading});
            chk("m_done1", {7'd0, done1}, {7'd0, committing});
            chk("m_done2", {7'd0, done2}, {7'd0, committing});
            chk("m_valid1", {7'd0, valid1}, {7'd0, mvalid});
            chk("m_valid2", {7'd0, valid2}, {7'd0, mvalid});
            chk("m_y1", {7'd0, y1}, {7'd0, my[0]});
            chk("m_y2", {6'd0, y2}, {6'd0, my});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eval_all(input string name, input logic [7:0] exp);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = {3'd0, 3'(i)};
            tick();
            chk(name, {7'd0, y1}, {7'd0, exp[i]});
        end
        in_valid = 1'b0;
        tick();
        chk({name, "_valid_off"}, {7'd0, valid1}, 8'd0);
    endtask

    // Shifts nbits of val LSB-first; one cfg_valid gap before bit gap_at (-1 = none)
    task automatic shift_bits(input logic [7:0] val, input int nbits, input int gap_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_at) begin
                cfg_valid = 1'b0;
                tick();
            end
            cfg_valid = 1'b1;
            cfg_bit = val[i];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_bit = 1'b0;
    endtask

    task automatic start_load(input logic junk_bit);
        cfg_start = 1'b1;
        cfg_valid = junk_bit;
        cfg_bit = junk_bit;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit = 1'b0;
        chk("ready_after_start", {7'd0, ready1}, 8'd1);
    endtask

    task automatic full_load(input logic [7:0] val, input int gap_at, input logic junk_bit);
        start_load(junk_bit);
        shift_bits(val, 8, gap_at);
        chk("done_in_commit", {7'd0, done1}, 8'd1);
        chk("ready_in_commit", {7'd0, ready1}, 8'd0);
        tick();
        chk("done_after_commit", {7'd0, done1}, 8'd0);
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        chk("rst_ready", {7'd0, ready1}, 8'd0);
        chk("rst_done", {7'd0, done1}, 8'd0);
        chk("rst_valid", {7'd0, valid1}, 8'd0);
        chk("rst_y", {6'd0, y2}, 8'd0);
        reset = 1'b1;
        tick();

        eval_all("default_tab", 8'h39);

        // Evaluate input 0 continuously while loading 8'hFE over 8'h39
        in_valid = 1'b1;
        in_data = '0;
        start_load(1'b0);
        chk("during_load_y", {7'd0, y1}, 8'd1);
        shift_bits(8'hFE, 8, -1);
        chk("commit_cycle_done", {7'd0, done1}, 8'd1);
        chk("before_commit_y", {7'd0, y1}, 8'd1);
        tick();
        chk("commit_sample_y", {7'd0, y1}, 8'd1);
        tick();
        chk("after_commit_y", {7'd0, y1}, 8'd0);
        in_valid = 1'b0;
        tick();

        full_load(8'hE8, 3, 1'b0);
        eval_all("majority", 8'hE8);

        // Abort: 5 ones, restart with a junk bit in the restart cycle, then all zeros
        start_load(1'b0);
        shift_bits(8'hFF, 5, -1);
        full_load(8'h00, -1, 1'b1);
        eval_all("abort_zero", 8'h00);

        full_load(8'hE8, -1, 1'b0);
        in_valid = 1'b1;
        in_data = {3'b110, 3'b001};
        tick();
        chk("multi_y", {6'd0, y2}, 8'h02);
        chk("multi_valid", {7'd0, valid2}, 8'd1);
        in_valid = 1'b0;
        tick();
        chk("hold_y", {6'd0, y2}, 8'h02);

        // Reset mid-load
        start_load(1'b0);
        shift_bits(8'hFF, 6, -1);
        in_valid = 1'b1;
        in_data = 6'd3;
        reset = 1'b0;
        tick();
        chk("midrst_ready", {7'd0, ready1}, 8'd0);
        chk("midrst_valid", {7'd0, valid1}, 8'd0);
        chk("midrst_y", {7'd0, y1}, 8'd0);
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        eval_all("after_reset", 8'h39);

        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_lut.md
# prog_lut

Run-time programmable N-input truth-table evaluator with CH parallel lookup channels. It generalises the fixed mux-based truth-table function to a table held in registers, loaded serially and committed atomically, with a registered, pipelined evaluation path. It sits wherever combinational glue logic must be changed without re-synthesis, and serves as the reference checker for the team's truth-table exercises.

## Interface
- N, 3, number of function inputs; table DEPTH = 2**N entries; legal range 1..6
- CH, 1, number of independent lookup channels sharing one table
- RESET_TABLE, 8'h39, DEPTH-bit table loaded at reset; bit i = output for input value i
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- cfg_start  input  1  pulse: begin a new table load and discard any partial load
- cfg_valid  input  1  cfg_bit is valid this cycle
- cfg_bit  input  1  next table bit, entry 0 first (LSB-first)
- cfg_ready  output  1  high in LOAD; a bit is accepted when cfg_valid & cfg_ready
- cfg_done  output  1  one-cycle pulse: new table became active this cycle
- in_valid  input  1  evaluate in_data this cycle
- in_data  input  CH*N  channel k occupies bits [k*N +: N]
- out_valid  output  1  out_y holds results of the in_valid from the previous cycle
- out_y  output  CH  bit k = active_table[in_data channel k]

## Operation
- Registers: active_table (DEPTH bits), shadow_table (DEPTH bits), bit counter cnt ($clog2(DEPTH)+1 bits), FSM state.
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE: cfg_ready = 0. cfg_start causes the transition to LOAD, with cnt cleared to 0.
  - LOAD: cfg_ready = 1. Each accepted bit is written to shadow_table[cnt], then cnt increments. Acceptance with cnt == DEPTH-1 causes the transition to COMMIT. cfg_start causes the transition to LOAD with cnt = 0, and a bit presented in that same cycle is ignored.
  - COMMIT: active_table <= shadow_table, cfg_done = 1, and the transition back to IDLE follows. cfg_start in COMMIT is ignored.
- Evaluation runs independently of the FSM in every state. Each channel indexes active_table with its own N-bit slice.
- The evaluation path always uses the active_table value present at the sampling edge. A lookup sampled in the COMMIT cycle uses the old table, and lookups from the next cycle onward use the new table.
- While a load is in progress, the old table stays fully in use. A partial load is never visible on out_y.
- Reset (reset = 0 at a rising edge) sets:
  - active_table = RESET_TABLE, shadow_table = 0, cnt = 0
  - state = IDLE, cfg_ready = 0, cfg_done = 0, out_valid = 0, out_y = 0
- Reset mid-load aborts the load, and the table reverts to RESET_TABLE.

## Timing
- Evaluation latency is 1 cycle. in_valid/in_data sampled at edge t produce out_valid/out_y valid after edge t, held until edge t+1.
- Evaluation throughput is one lookup per channel per cycle, with no stalls and no backpressure.
- When in_valid = 0, out_valid goes to 0 and out_y holds its last value.
- A full load takes:
  - 1 cycle for cfg_start
  - DEPTH accepted bits (cfg_valid gaps allowed)
  - 1 COMMIT cycle
- cfg_done is asserted exactly in the COMMIT cycle. The first lookup using the new table is sampled on the edge after COMMIT.
- Minimum start-to-new-table time is DEPTH+2 cycles.

## Structure
- Package prog_lut_pkg contains:
  - the state enum lut_state_t {IDLE, LOAD, COMMIT}
  - the function lut_depth(n) returning 2**n
  - the default-table constant LUT_TABLE_DEFAULT = 8'h39
- Sub-module prog_lut_loader holds the FSM, cnt and shadow_table, and outputs cfg_ready, cfg_done and commit_table.
- The top module holds active_table and the CH-wide registered lookup, generated per channel.

## Test plan
- Default table (N=3, CH=1): apply reset, then in_data 0..7 on consecutive cycles. Required out_y sequence is 1,0,0,1,1,1,0,0, each one cycle after its input.
- Load a majority function: cfg_start, then bits of 8'hE8 LSB-first with one cfg_valid gap. Required: cfg_done pulses once, and in_data 0..7 then gives 0,0,0,1,0,1,1,1.
- Evaluate during a load: stream in_data = 3'b000 every cycle while loading 8'hFE. out_y must stay 1 through the COMMIT cycle and become 0 on the first output after it.
- Abort a load with cfg_start: shift 5 bits of 8'hFF, pulse cfg_start, then load 8'h00. After cfg_done, every input must give 0, with no stale 1s.
- Reset mid-load: load 8'hFF up to 6 bits, then assert reset = 0 for 1 cycle. Required: cfg_ready = 0, out_valid = 0, and the table back to 8'h39.
- Multi-channel (N=3, CH=2): load 8'hE8 and drive in_data = {3'b110, 3'b001}. Required out_y = 2'b10 one cycle later, and out_valid = 1.
